// File: rtl/he_encode_arb.sv
// Round-robin arbiter sharing one registered Hamming parity generator between N requesters.
// Codewords leave as {parity, data} with the owning requester ID over a valid/ready port.

module he_parity_gen #(
    parameter int unsigned K = 4,
    parameter int unsigned M = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [K-1:0] din_i,
    output logic [M-1:0] parity_o
);

    logic [M-1:0] parity_d, parity_q;

    // Codeword position (1-based) of data bit idx: data fills the non-power-of-two slots.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned cnt;
        int unsigned pos;
        cnt = 0;
        pos = 0;
        for (int unsigned q = 1; q < (32'd1 << M); q++) begin
            if ((q & (q - 1)) != 0) begin
                if (cnt == idx && pos == 0) pos = q;
                cnt++;
            end
        end
        return pos;
    endfunction

    always_comb begin
        parity_d = '0;
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < M; j++) begin
                if (((data_pos(i) >> j) & 32'd1) != 0) parity_d[j] = parity_d[j] ^ din_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) parity_q <= '0;
        else         parity_q <= parity_d;
    end

    assign parity_o = parity_q;

endmodule

module he_encode_arb #(
    parameter int unsigned K   = 4,
    parameter int unsigned M   = 3,
    parameter int unsigned N   = 2,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_valid_i,
    input  logic [N*K-1:0]   req_data_i,
    output logic [N-1:0]     req_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [K+M-1:0]   out_code_o,
    output logic [IDW-1:0]   out_id_o,
    output logic             busy_o,
    output logic [15:0]      enc_cnt_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

    state_e         state_d, state_q;
    logic [IDW-1:0] ptr_d, ptr_q;
    logic [IDW-1:0] id_d, id_q;
    logic [K-1:0]   dreg_d, dreg_q;
    logic [15:0]    cnt_d, cnt_q;
    logic [M-1:0]   parity;

    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic           can_grant;
    logic           accept;

    he_parity_gen #(
        .K (K),
        .M (M)
    ) u_parity_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .din_i    (dreg_q),
        .parity_o (parity)
    );

    // First valid requester at or after the pointer, searching modulo N.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned off = 0; off < N; off++) begin
            if (!gnt_any && req_valid_i[(32'(ptr_q) + off) % N]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'((32'(ptr_q) + off) % N);
            end
        end
    end

    assign can_grant   = (state_q == StIdle) || ((state_q == StOut) && out_ready_i);
    assign accept      = rst_ni && can_grant && gnt_any;
    assign req_ready_o = accept ? (N'(1) << gnt_idx) : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        dreg_d  = dreg_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: if (accept) state_d = StCalc;
            StCalc: state_d = StOut;
            StOut: begin
                if (out_ready_i) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = accept ? StCalc : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            dreg_d = req_data_i[32'(gnt_idx) * K +: K];
            id_d   = gnt_idx;
            ptr_d  = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            id_q    <= '0;
            dreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            dreg_q  <= dreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid_o = (state_q == StOut);
    assign out_code_o  = out_valid_o ? {parity, dreg_q} : '0;
    assign out_id_o    = out_valid_o ? id_q : '0;
    assign busy_o      = (state_q == StCalc) || (state_q == StOut);
    assign enc_cnt_o   = cnt_q;

endmodule

// File: tb/tb_he_encode_arb.sv
// Randomized scoreboard bench for he_encode_arb: grants push expected codewords,
// a negedge monitor pops and compares on every output handshake.

module tb_he_encode_arb;

    localparam int K = 4;
    localparam int M = 3;
    localparam int N = 2;

    logic             clk_i;
    logic             rst_ni;
    logic [N-1:0]     req_valid_i;
    logic [N*K-1:0]   req_data_i;
    logic [N-1:0]     req_ready_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [K+M-1:0]   out_code_o;
    logic [0:0]       out_id_o;
    logic             busy_o;
    logic [15:0]      enc_cnt_o;

    he_encode_arb #(
        .K   (K),
        .M   (M),
        .N   (N),
        .IDW (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_code_o  (out_code_o),
        .out_id_o    (out_id_o),
        .busy_o      (busy_o),
        .enc_cnt_o   (enc_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [6:0] code;
        int         id;
        int         cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          g_log[$];
    int          hs_cyc[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          model_ptr = 0;
    logic [15:0] model_cnt = '0;
    logic [N-1:0] acc_mask = '0;
    bit          presenting = 0;
    logic [6:0]  held_code, last_code;
    logic [0:0]  held_id, last_id;
    int          g;
    exp_t        e;

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference codeword: the parity value that makes the Hamming syndrome of the
    // assembled 7-bit word zero (parity at positions 1,2,4; data fills 3,5,6,7).
    function automatic logic [6:0] ref_code(input logic [3:0] d);
        logic [2:0] p;
        int syn, di;
        logic b;
        for (int pv = 0; pv < 8; pv++) begin
            p   = pv[2:0];
            syn = 0;
            di  = 0;
            for (int pos = 1; pos <= 7; pos++) begin
                if (pos == 1)      b = p[0];
                else if (pos == 2) b = p[1];
                else if (pos == 4) b = p[2];
                else begin
                    b = d[di];
                    di++;
                end
                if (b) syn = syn ^ pos;
            end
            if (syn == 0) return {p, d};
        end
        return 'x;
    endfunction

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            acc_mask = '0;
        end else begin
            acc_mask = req_ready_o;
            if (req_ready_o != '0) begin
                g = -1;
                for (int off = 0; off < N; off++)
                    if (g < 0 && req_valid_i[(model_ptr + off) % N]) g = (model_ptr + off) % N;
                check("req_ready_onehot", 64'($onehot(req_ready_o)), 1);
                check("grant_has_valid", 64'(g >= 0), 1);
                if (g >= 0) begin
                    check("grant_rr", req_ready_o, 64'(1 << g));
                    check("grant_when_blocked", out_valid_o & ~out_ready_i, 0);
                    e.code = ref_code(req_data_i[g*K +: K]);
                    e.id   = g;
                    e.cyc  = cyc;
                    sb_q.push_back(e);
                    g_log.push_back(g);
                    model_ptr = (g + 1) % N;
                end
            end
            if (out_valid_o) begin
                check("busy_in_out", busy_o, 1);
                if (!presenting) begin
                    presenting = 1;
                    held_code  = out_code_o;
                    held_id    = out_id_o;
                    check("output_expected", 64'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        check("out_code", out_code_o, sb_q[0].code);
                        check("out_id", out_id_o, 64'(sb_q[0].id));
                        check("latency", 64'(cyc - sb_q[0].cyc), 2);
                    end
                end else begin
                    check("hold_code", out_code_o, held_code);
                    check("hold_id", out_id_o, held_id);
                end
                if (out_ready_i) begin
                    check("enc_cnt_at_hs", enc_cnt_o, model_cnt);
                    model_cnt++;
                    last_code = out_code_o;
                    last_id   = out_id_o;
                    hs_cyc.push_back(cyc);
                    if (sb_q.size() != 0) void'(sb_q.pop_front());
                    presenting = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int i, input logic [3:0] d);
        req_valid_i[i]       = 1'b1;
        req_data_i[i*K +: K] = d;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (acc_mask[i]) break;
        end
        check("send_accepted", acc_mask[i], 1);
        req_valid_i[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 60; t++) begin
            if (sb_q.size() == 0 && !busy_o) break;
            tick();
        end
        check("drain_timeout", 64'(t < 60), 1);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        sb_q.delete();
        presenting = 0;
        model_ptr  = 0;
        model_cnt  = '0;
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_code", out_code_o, 0);
        check("rst_out_id", out_id_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_enc_cnt", enc_cnt_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [3:0] words[4];
        logic [6:0] codes[4];
        words = '{4'b1011, 4'b0000, 4'b1111, 4'b0001};
        codes = '{7'h1B, 7'h00, 7'h7F, 7'h31};

        rst_ni      = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        out_ready_i = 1'b1;
        #2;
        do_reset();
        tick();

        // Single-word codewords from requester 0.
        for (int w = 0; w < 4; w++) begin
            send(0, words[w]);
            wait_idle();
            check("known_code", last_code, codes[w]);
            check("known_id", last_id, 0);
            check("known_cnt", enc_cnt_o, 64'(w + 1));
        end

        // Both requesters always valid: alternating grants, one codeword per 2 cycles.
        hs_cyc.delete();
        g_log.delete();
        req_valid_i = 2'b11;
        for (int t = 0; t < 60 && hs_cyc.size() < 8; t++) begin
            req_data_i = N*K'($urandom);
            tick();
        end
        req_valid_i = '0;
        check("alt_hs_count", 64'(hs_cyc.size() >= 8), 1);
        if (hs_cyc.size() >= 8) check("alt_hs_spacing", 64'(hs_cyc[7] - hs_cyc[0]), 14);
        for (int k = 1; k < 8 && k < g_log.size(); k++)
            check("alt_grant", 64'(g_log[k] != g_log[k-1]), 1);
        wait_idle();

        // Backpressure, then release with requester 1 waiting.
        out_ready_i = 1'b0;
        send(0, 4'b0110);
        for (int t = 0; t < 10 && !out_valid_o; t++) tick();
        req_valid_i = 2'b10;
        req_data_i[K +: K] = 4'b1001;
        repeat (5) tick();
        check("bp_cnt_hold", enc_cnt_o, model_cnt);
        check("bp_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("bp_release_ready", req_ready_o, 2'b10);
        tick();
        req_valid_i = '0;
        wait_idle();

        // Reset while in CALC; the pointer was 1 before reset.
        send(0, 4'b0101);
        check("in_calc", 64'({busy_o, out_valid_o}), 2'b10);
        do_reset();
        tick();
        g_log.delete();
        req_valid_i = 2'b11;
        req_data_i  = 8'h3C;
        for (int t = 0; t < 10 && g_log.size() == 0; t++) tick();
        req_valid_i = '0;
        check("ptr_reset_grant", 64'(g_log.size() != 0 ? g_log[0] : -1), 0);
        wait_idle();
        send(1, 4'b1110);
        wait_idle();
        check("req1_alone_id", last_id, 1);

        // Counter wrap.
        force dut.cnt_q = 16'hFFFF;
        #2;
        release dut.cnt_q;
        model_cnt = 16'hFFFF;
        send(1, 4'b0011);
        wait_idle();
        check("cnt_wrap", enc_cnt_o, 16'h0000);

        // Randomized traffic with random backpressure and dropped requests.
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i] || !req_valid_i[i]) begin
                    req_valid_i[i] = ($urandom_range(0, 1) == 1);
                    req_data_i[i*K +: K] = 4'($urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid_i[i] = 1'b0;
                end
            end
            out_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid_i = '0;
        out_ready_i = 1'b1;
        wait_idle();
        check("final_sb_empty", 64'(sb_q.size()), 0);
        check("final_cnt", enc_cnt_o, model_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
